// File: rtl/mux_wreg_pipe.sv
// Write-register selector with a DEPTH-stage write-back delay line and
// read-after-write stall detection against every in-flight destination.
module mux_wreg_pipe #(
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 3,
  parameter int SP_IDX = 29,
  parameter int RA_IDX = 31
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  input  logic [1:0]                     sel,
  input  logic [ADDR_W-1:0]              rt,
  input  logic [ADDR_W-1:0]              rd,
  input  logic                           wr_en_in,
  input  logic [ADDR_W-1:0]              src_a,
  input  logic [ADDR_W-1:0]              src_b,
  input  logic                           flush,
  output logic                           in_ready,
  output logic                           stall,
  output logic                           out_valid,
  output logic [ADDR_W-1:0]              out_addr,
  output logic                           out_wr_en,
  output logic [$clog2(DEPTH+1)-1:0]     pending_cnt
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]  valid_r;
  logic [DEPTH-1:0]  wren_r;
  logic [ADDR_W-1:0] addr_r [DEPTH];
  logic [CNT_W-1:0]  cnt_r;

  logic [DEPTH-1:0]  valid_nx_s;
  logic [DEPTH-1:0]  wren_nx_s;
  logic [ADDR_W-1:0] addr_nx_s [DEPTH];
  logic [CNT_W-1:0]  cnt_nx_s;
  logic [ADDR_W-1:0] dest_s;
  logic              stall_s;
  logic              accept_s;

  // Destination index decode
  always_comb begin
    dest_s = rt;
    case (sel)
      2'b00:   dest_s = rt;
      2'b01:   dest_s = ADDR_W'(SP_IDX);
      2'b10:   dest_s = ADDR_W'(RA_IDX);
      2'b11:   dest_s = rd;
      default: dest_s = rt;
    endcase
  end

  // RAW hazard: any pending non-zero write matching either source
  always_comb begin
    stall_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      stall_s = stall_s | (valid_r[i] & wren_r[i] &
                           (addr_r[i] != {ADDR_W{1'b0}}) &
                           ((addr_r[i] == src_a) | (addr_r[i] == src_b)));
    end
  end

  // Next delay-line contents and occupancy
  always_comb begin
    accept_s   = in_valid & ~stall_s & ~flush;
    valid_nx_s = {DEPTH{1'b0}};
    wren_nx_s  = {DEPTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      addr_nx_s[i] = {ADDR_W{1'b0}};
    end
    if (flush) begin
      valid_nx_s = {DEPTH{1'b0}};
    end else begin
      // Stage 0 takes the new entry or a bubble; zero-register writes are dropped
      valid_nx_s[0] = accept_s;
      addr_nx_s[0]  = accept_s ? dest_s : {ADDR_W{1'b0}};
      wren_nx_s[0]  = accept_s & wr_en_in & (dest_s != {ADDR_W{1'b0}});
      for (int i = 1; i < DEPTH; i++) begin
        valid_nx_s[i] = valid_r[i-1];
        addr_nx_s[i]  = addr_r[i-1];
        wren_nx_s[i]  = wren_r[i-1];
      end
    end
    cnt_nx_s = {CNT_W{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      cnt_nx_s = cnt_nx_s + CNT_W'(valid_nx_s[i]);
    end
  end

  // Stage registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_r <= {DEPTH{1'b0}};
      wren_r  <= {DEPTH{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        addr_r[i] <= {ADDR_W{1'b0}};
      end
    end else begin
      valid_r <= valid_nx_s;
      wren_r  <= wren_nx_s;
      cnt_r   <= cnt_nx_s;
      for (int i = 0; i < DEPTH; i++) begin
        addr_r[i] <= addr_nx_s[i];
      end
    end
  end

  assign out_valid   = valid_r[DEPTH-1];
  assign out_addr    = addr_r[DEPTH-1];
  assign out_wr_en   = valid_r[DEPTH-1] & wren_r[DEPTH-1];
  assign stall       = stall_s;
  assign in_ready    = ~stall_s;
  assign pending_cnt = cnt_r;

endmodule

// File: tb/tb_mux_wreg_pipe.sv
// Randomized and directed bench for mux_wreg_pipe against a timestamped
// in-flight-list model of the write-back delay line.
module tb_mux_wreg_pipe;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 3;
  localparam int SP_IDX = 29;
  localparam int RA_IDX = 31;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic [1:0]        sel;
  logic [ADDR_W-1:0] rt, rd, src_a, src_b;
  logic              wr_en_in, flush;
  logic              in_ready, stall, out_valid, out_wr_en;
  logic [ADDR_W-1:0] out_addr;
  logic [CNT_W-1:0]  pending_cnt;

  always #5 clk = ~clk;

  mux_wreg_pipe #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .SP_IDX(SP_IDX), .RA_IDX(RA_IDX)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .sel(sel), .rt(rt), .rd(rd),
    .wr_en_in(wr_en_in), .src_a(src_a), .src_b(src_b), .flush(flush),
    .in_ready(in_ready), .stall(stall), .out_valid(out_valid), .out_addr(out_addr),
    .out_wr_en(out_wr_en), .pending_cnt(pending_cnt)
  );

  // Model: each accepted write remembers the edge it was accepted on
  typedef struct {int issue; int addr; bit we;} ent_t;
  ent_t inflight[$];
  int   edge_n = 0;

  int checks_total  = 0;
  int checks_passed = 0;
  int obs_stall     = 0;
  int obs_pend      = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks_total++;
    if (obs == exp) checks_passed++;
    else $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp, edge_n);
  endtask

  function automatic int model_dest(input int s, input int rtv, input int rdv);
    case (s)
      0:       return rtv;
      1:       return SP_IDX;
      2:       return RA_IDX;
      default: return rdv;
    endcase
  endfunction

  function automatic bit model_stall(input int sa, input int sb);
    foreach (inflight[i])
      if (inflight[i].we && inflight[i].addr != 0 &&
          (inflight[i].addr == sa || inflight[i].addr == sb)) return 1'b1;
    return 1'b0;
  endfunction

  // One clock: drive, check the state left by the previous edge, advance model
  task automatic cycle(input bit iv, input int s, input int rtv, input int rdv, input bit we,
                       input int sa, input int sb, input bit fl, input bit rst);
    bit exp_stall, acc, ev, ewe;
    int ea, d;
    @(negedge clk);
    reset = rst; in_valid = iv; sel = 2'(s); rt = ADDR_W'(rtv); rd = ADDR_W'(rdv);
    wr_en_in = we; src_a = ADDR_W'(sa); src_b = ADDR_W'(sb); flush = fl;
    #1;
    exp_stall = model_stall(sa, sb);
    ev = 1'b0; ea = 0; ewe = 1'b0;
    foreach (inflight[i])
      if (edge_n - inflight[i].issue == DEPTH - 1) begin
        ev = 1'b1; ea = inflight[i].addr; ewe = inflight[i].we;
      end
    check_eq("stall", int'(stall), int'(exp_stall));
    check_eq("in_ready", int'(in_ready), int'(!exp_stall));
    check_eq("out_valid", int'(out_valid), int'(ev));
    check_eq("out_addr", int'(out_addr), ea);
    check_eq("out_wr_en", int'(out_wr_en), int'(ewe));
    check_eq("pending_cnt", int'(pending_cnt), inflight.size());
    obs_stall = int'(stall);
    obs_pend  = int'(pending_cnt);
    acc = rst && !fl && iv && !exp_stall;
    d   = model_dest(s, rtv, rdv);
    @(posedge clk);
    edge_n++;
    if (!rst || fl) begin
      inflight.delete();
    end else begin
      for (int i = inflight.size() - 1; i >= 0; i--)
        if (edge_n - inflight[i].issue >= DEPTH) inflight.delete(i);
      if (acc) inflight.push_back('{edge_n, d, we && d != 0});
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 0, 0, 0, 1'b0, 0, 0, 1'b0, 1'b1);
  endtask

  initial begin
    int nstall, peak;
    reset = 1'b0; in_valid = 1'b1; sel = 2'b00; rt = '0; rd = '0;
    wr_en_in = 1'b1; src_a = '0; src_b = '0; flush = 1'b0;
    @(posedge clk);

    // Reset held with a valid instruction on the inputs
    cycle(1'b1, 0, 5, 6, 1'b1, 0, 0, 1'b0, 1'b0);
    cycle(1'b1, 0, 5, 6, 1'b1, 0, 0, 1'b0, 1'b0);
    check_eq("reset_pend", obs_pend, 0);
    cycle(1'b1, 3, 4, 7, 1'b1, 0, 0, 1'b0, 1'b1);
    idle(DEPTH + 1);

    // Selection: all four codes back to back
    peak = 0;
    for (int s = 0; s < 4; s++) cycle(1'b1, s, 8, 12, 1'b1, 0, 0, 1'b0, 1'b1);
    for (int k = 0; k < DEPTH + 1; k++) begin
      cycle(1'b0, 0, 0, 0, 1'b0, 0, 0, 1'b0, 1'b1);
      if (obs_pend > peak) peak = obs_pend;
    end
    check_eq("sel_peak_pend", peak, DEPTH);

    // Zero register never creates a hazard
    nstall = 0;
    cycle(1'b1, 0, 0, 0, 1'b1, 0, 0, 1'b0, 1'b1);
    for (int k = 0; k < DEPTH + 1; k++) begin
      cycle(1'b0, 0, 0, 0, 1'b0, 0, 0, 1'b0, 1'b1);
      nstall += obs_stall;
    end
    check_eq("zero_reg_stall", nstall, 0);

    // Back-to-back dependency on r9 stalls exactly DEPTH cycles
    nstall = 0;
    cycle(1'b1, 0, 9, 0, 1'b1, 0, 0, 1'b0, 1'b1);
    for (int k = 0; k < DEPTH + 1; k++) begin
      cycle(1'b1, 3, 1, 10, 1'b1, 3, 9, 1'b0, 1'b1);
      nstall += obs_stall;
    end
    check_eq("hazard_len", nstall, DEPTH);
    idle(DEPTH + 1);

    // Flush a full pipe together with a valid instruction
    for (int k = 0; k < DEPTH; k++) cycle(1'b1, 3, 0, 20 + k, 1'b1, 0, 0, 1'b0, 1'b1);
    cycle(1'b1, 3, 0, 25, 1'b1, 0, 0, 1'b1, 1'b1);
    idle(DEPTH + 1);

    // Reset mid-flight
    cycle(1'b1, 0, 14, 0, 1'b1, 0, 0, 1'b0, 1'b1);
    cycle(1'b1, 0, 15, 0, 1'b1, 0, 0, 1'b0, 1'b1);
    cycle(1'b1, 0, 16, 0, 1'b1, 0, 0, 1'b0, 1'b0);
    idle(DEPTH + 1);

    // Random traffic over a small register range to provoke hazards
    for (int k = 0; k < 600; k++) begin
      cycle($urandom_range(3, 0) != 0, int'($urandom_range(3, 0)),
            int'($urandom_range(15, 0)), int'($urandom_range(15, 0)),
            $urandom_range(4, 0) != 0,
            int'($urandom_range(15, 0)), int'($urandom_range(15, 0)),
            $urandom_range(19, 0) == 0, $urandom_range(39, 0) != 0);
    end
    idle(DEPTH + 1);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end
endmodule
